// File: rtl/alu_sequencer_if.sv
// Instruction-issue and ALU-side signal bundle for the ALU sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface alu_sequencer_if #(
  parameter int bit_size = 15
);
  logic                ins_valid;
  logic                ins_ready;
  logic [1:0]          ins_op;
  logic [bit_size:0]   ins_data;
  logic [bit_size:0]   alu_a;
  logic [bit_size:0]   alu_b;
  logic                ALUand;
  logic                ALUadd;
  logic [bit_size:0]   alu_out;
  logic [bit_size:0]   acc;
  logic                zero;
  logic                done;

  modport slave (
    input  ins_valid, ins_op, ins_data, alu_out,
    output ins_ready, alu_a, alu_b, ALUand, ALUadd, acc, zero, done
  );

  modport master (
    output ins_valid, ins_op, ins_data, alu_out,
    input  ins_ready, alu_a, alu_b, ALUand, ALUadd, acc, zero, done
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one LOAD/AND/ADD/CLR instruction at a time through an external ALU
// into an accumulator: IDLE (accept) -> EXEC (ALU selects) -> WB (done pulse).
module alu_sequencer #(
  parameter int bit_size = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.slave  bus
);
  localparam int W = bit_size + 1;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           w_hs;
  logic [1:0]     r_op;
  logic [W-1:0]   r_data;
  logic [W-1:0]   r_acc;
  logic [W-1:0]   w_acc_next;
  logic           r_zero;
  logic           r_done;
  logic           r_and;
  logic           r_add;
  logic           r_ready;

  assign w_hs = bus.ins_valid & bus.ins_ready;

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_next = S_EXEC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Accumulator value committed at the end of EXEC
  always_comb begin
    w_acc_next = r_acc;
    case (r_op)
      OP_AND:  w_acc_next = bus.alu_out;
      OP_ADD:  w_acc_next = bus.alu_out;
      OP_LOAD: w_acc_next = r_data;
      OP_CLR:  w_acc_next = {W{1'b0}};
      default: w_acc_next = r_acc;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Instruction capture and accumulator/zero update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= 2'b00;
      r_data <= {W{1'b0}};
      r_acc  <= {W{1'b0}};
      r_zero <= 1'b1;
    end else begin
      if ((r_state == S_IDLE) && w_hs) begin
        r_op   <= bus.ins_op;
        r_data <= bus.ins_data;
      end
      if (r_state == S_EXEC) begin
        r_acc  <= w_acc_next;
        r_zero <= (w_acc_next == {W{1'b0}});
      end
    end
  end

  // Registered control outputs; selects are high exactly during EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_and   <= 1'b0;
      r_add   <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_and   <= (w_next == S_EXEC) && (bus.ins_op == OP_AND);
      r_add   <= (w_next == S_EXEC) && (bus.ins_op == OP_ADD);
      r_done  <= (w_next == S_WB);
      r_ready <= (w_next == S_IDLE);
    end
  end

  assign bus.ins_ready = r_ready & rst_n;
  assign bus.alu_a     = r_acc;
  assign bus.alu_b     = r_data;
  assign bus.ALUand    = r_and;
  assign bus.ALUadd    = r_add;
  assign bus.acc       = r_acc;
  assign bus.zero      = r_zero;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural 16-bit ALU.
module tb_alu_sequencer;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_sequencer_if #(.bit_size(15)) bus_if ();

  alu_sequencer #(.bit_size(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  assign bus_if.alu_out = bus_if.ALUand ? (bus_if.alu_a & bus_if.alu_b) :
                          bus_if.ALUadd ? (bus_if.alu_a + bus_if.alu_b) : 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Selects must never be active together, every cycle outside reset
  always @(negedge clk) begin
    if (rst_n === 1'b1) chk("sel_exclusive", {31'd0, bus_if.ALUand & bus_if.ALUadd}, 32'd0);
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus_if.ins_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, bus_if.ins_ready}, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [15:0] data,
                       input logic [15:0] exp_acc, input logic exp_zero,
                       input logic exp_and, input logic exp_add);
    wait_ready();
    bus_if.ins_valid = 1'b1;
    bus_if.ins_op    = op;
    bus_if.ins_data  = data;
    @(negedge clk);
    bus_if.ins_valid = 1'b0;
    chk({tag, "_exec_ready"}, {31'd0, bus_if.ins_ready}, 32'd0);
    chk({tag, "_exec_and"},   {31'd0, bus_if.ALUand}, {31'd0, exp_and});
    chk({tag, "_exec_add"},   {31'd0, bus_if.ALUadd}, {31'd0, exp_add});
    chk({tag, "_exec_done"},  {31'd0, bus_if.done}, 32'd0);
    chk({tag, "_exec_alub"},  {16'd0, bus_if.alu_b}, {16'd0, data});
    @(negedge clk);
    chk({tag, "_wb_done"},    {31'd0, bus_if.done}, 32'd1);
    chk({tag, "_wb_acc"},     {16'd0, bus_if.acc}, {16'd0, exp_acc});
    chk({tag, "_wb_zero"},    {31'd0, bus_if.zero}, {31'd0, exp_zero});
    chk({tag, "_wb_sel"},     {30'd0, bus_if.ALUand, bus_if.ALUadd}, 32'd0);
    chk({tag, "_wb_ready"},   {31'd0, bus_if.ins_ready}, 32'd0);
    @(negedge clk);
    chk({tag, "_idle_done"},  {31'd0, bus_if.done}, 32'd0);
    chk({tag, "_idle_ready"}, {31'd0, bus_if.ins_ready}, 32'd1);
  endtask

  initial begin
    logic [1:0]  ops [4];
    logic [15:0] dat [4];
    logic [15:0] accs [4];
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus_if.ins_valid = 1'b0;
    bus_if.ins_op    = 2'b00;
    bus_if.ins_data  = 16'h0000;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_ready_low", {31'd0, bus_if.ins_ready}, 32'd0);
    chk("rst_acc",  {16'd0, bus_if.acc}, 32'd0);
    chk("rst_zero", {31'd0, bus_if.zero}, 32'd1);
    chk("rst_done", {31'd0, bus_if.done}, 32'd0);
    chk("rst_sel",  {30'd0, bus_if.ALUand, bus_if.ALUadd}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", {31'd0, bus_if.ins_ready}, 32'd1);
    @(negedge clk);

    // LOAD then ADD
    do_op("ld1234", 2'b00, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0);
    do_op("add1",   2'b10, 16'h0001, 16'h1235, 1'b0, 1'b0, 1'b1);

    // ADD wraparound
    do_op("ldffff", 2'b00, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    do_op("addwrap", 2'b10, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b1);

    // AND to zero, then CLR
    do_op("ld0f0f", 2'b00, 16'h0F0F, 16'h0F0F, 1'b0, 1'b0, 1'b0);
    do_op("and",    2'b01, 16'hF0F0, 16'h0000, 1'b1, 1'b1, 1'b0);
    do_op("ld55",   2'b00, 16'h0055, 16'h0055, 1'b0, 1'b0, 1'b0);
    do_op("clr",    2'b11, 16'hBEEF, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Back-to-back with ins_valid held high: one handshake every 3 cycles
    ops[0] = 2'b00; dat[0] = 16'h0003; accs[0] = 16'h0003;
    ops[1] = 2'b10; dat[1] = 16'h0004; accs[1] = 16'h0007;
    ops[2] = 2'b01; dat[2] = 16'h0005; accs[2] = 16'h0005;
    ops[3] = 2'b10; dat[3] = 16'hFFFB; accs[3] = 16'h0000;
    bus_if.ins_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_ready", {31'd0, bus_if.ins_ready}, 32'd1);
      bus_if.ins_op   = ops[i];
      bus_if.ins_data = dat[i];
      @(negedge clk);
      chk("b2b_exec_ready", {31'd0, bus_if.ins_ready}, 32'd0);
      chk("b2b_exec_done",  {31'd0, bus_if.done}, 32'd0);
      @(negedge clk);
      chk("b2b_wb_done", {31'd0, bus_if.done}, 32'd1);
      chk("b2b_wb_acc",  {16'd0, bus_if.acc}, {16'd0, accs[i]});
      chk("b2b_wb_ready", {31'd0, bus_if.ins_ready}, 32'd0);
      @(negedge clk);
      chk("b2b_idle_done", {31'd0, bus_if.done}, 32'd0);
    end
    bus_if.ins_valid = 1'b0;
    chk("b2b_zero", {31'd0, bus_if.zero}, 32'd1);

    // Reset during EXEC discards the instruction
    do_op("ld10", 2'b00, 16'h0010, 16'h0010, 1'b0, 1'b0, 1'b0);
    wait_ready();
    bus_if.ins_valid = 1'b1;
    bus_if.ins_op    = 2'b10;
    bus_if.ins_data  = 16'h0005;
    @(negedge clk);
    bus_if.ins_valid = 1'b0;
    chk("mid_exec_add", {31'd0, bus_if.ALUadd}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_acc",   {16'd0, bus_if.acc}, 32'd0);
    chk("mid_zero",  {31'd0, bus_if.zero}, 32'd1);
    chk("mid_done",  {31'd0, bus_if.done}, 32'd0);
    chk("mid_sel",   {30'd0, bus_if.ALUand, bus_if.ALUadd}, 32'd0);
    chk("mid_ready", {31'd0, bus_if.ins_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_ready", {31'd0, bus_if.ins_ready}, 32'd1);
    @(negedge clk);
    chk("post_done", {31'd0, bus_if.done}, 32'd0);
    chk("post_acc",  {16'd0, bus_if.acc}, 32'd0);
    do_op("ldaa", 2'b00, 16'h00AA, 16'h00AA, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
